synth_buffer_i2s_tx: RTL
========================

SYNTH_BUFFER_I2S_TX -- requirements
Module: synth_buffer_i2s_tx

Interface
REQ-001 Parameter BCLK_HALF, default 16; clk cycles per BCLK half-period, legal values 2 to 255.
REQ-002 Parameter ADDR_W, default 10; sample-buffer depth is 2^ADDR_W 32-bit words.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000; byte address of buffer word 0.
REQ-004 Clocking and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-005 clk  in  1  system clock (FCLK_CLK0).
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 enable  in  1  level; 1 = play.
REQ-008 wr_ptr  in  ADDR_W  producer (PS) write index, next word to be written.
REQ-009 rd_ptr  out  ADDR_W  consumer index, next word to fetch.
REQ-010 BRAM_addr  out  32  byte address = BASE_ADDR + 4*rd_ptr.
REQ-011 BRAM_en  out  1  read strobe.
REQ-012 BRAM_we  out  4  tied to 4'b0000.
REQ-013 BRAM_dout  in  32  read data; [31:16] = left sample, [15:0] = right sample, two's complement.
REQ-014 underrun_cnt  out  16  saturating count of frames played as silence.
REQ-015 i2s_bclk, i2s_lrclk, i2s_sdata  out  1 each  I2S serial outputs (lrclk 0 = left).

Function
REQ-016 BCLK SHALL toggle every BCLK_HALF clk cycles while running; a 6-bit bit counter (0..63) SHALL advance on each BCLK falling edge.
REQ-017 lrclk and sdata SHALL change only on the clk cycle that drives BCLK low; lrclk = bit_cnt[5].
REQ-018 Frame = 64 BCLKs: shift word {1'b0, L[15:0], 15'b0, 1'b0, R[15:0], 15'b0}, MSB first, so each sample MSB appears one BCLK after its lrclk edge.
REQ-019 The shift register SHALL load from the holding register on the falling edge where bit_cnt wraps 63->0.
REQ-020 Fetch FSM states: F_IDLE, F_REQ, F_WAIT, F_FULL.
REQ-021 F_IDLE -> F_REQ when enable=1 and the holding register is empty and rd_ptr != wr_ptr.
REQ-022 F_REQ: BRAM_en=1 for exactly one cycle with BRAM_addr valid -> F_WAIT.
REQ-023 F_WAIT: capture BRAM_dout (one-cycle BRAM read latency) into the holding register, rd_ptr <= rd_ptr+1 mod 2^ADDR_W -> F_FULL.
REQ-024 F_FULL -> F_IDLE on the cycle the shift register consumes the holding register.
REQ-025 Empty condition: rd_ptr == wr_ptr; the buffer is never treated as full, and the producer is responsible for overrun.
REQ-026 If the holding register is empty at a frame load, the frame SHALL be all zeros and underrun_cnt SHALL increment, saturating at 16'hFFFF.
REQ-027 If wr_ptr changes on the same cycle as the empty compare, the registered value of wr_ptr from the previous cycle is used; no sample is lost, only delayed one frame at most.
REQ-028 enable 1->0: the current frame completes, then BCLK, lrclk and sdata hold 0 and bit_cnt = 0; the holding register and rd_ptr are retained.
REQ-029 enable 0->1: the first BCLK rising edge occurs BCLK_HALF cycles after enable is sampled high; the frame starts at bit_cnt 0.
REQ-030 BRAM_en SHALL be 0 except in F_REQ.

Reset
REQ-031 rst SHALL take effect on the next clk edge regardless of state, including mid-frame or mid-fetch.
REQ-032 Reset values: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, BRAM_en=0, rd_ptr=0, BRAM_addr=BASE_ADDR, underrun_cnt=0, FSM=F_IDLE, holding register empty, divider and bit_cnt = 0.

Structure
REQ-033 Package synth_audio_pkg SHALL hold FRAME_BITS=64, SAMPLE_W=16 and the fetch-state enum type.
REQ-034 Sub-module i2s_clk_gen (BCLK divider, fall/rise strobes, bit_cnt) SHALL be instantiated once.

Verification
REQ-035 Preload word0 = 32'h8001_7FFE, wr_ptr=1, enable=1 -> sdata shows 1000_0000_0000_0001 during bits 1..16 and 0111_1111_1111_1110 during bits 33..48; rd_ptr=1; underrun_cnt=0.
REQ-036 wr_ptr=0, enable=1 for 3 frames -> sdata constantly 0, underrun_cnt=3, BRAM_en never asserted.
REQ-037 ADDR_W=2, rd_ptr=3, wr_ptr=1 -> fetch addresses BASE+12, BASE+0, then stall; rd_ptr wraps 3->0->1.
REQ-038 BCLK_HALF=4 -> BCLK period 8 clk cycles and lrclk period 512 clk cycles, measured.
REQ-039 Assert rst for one cycle at bit_cnt=20 while in F_WAIT -> next cycle all REQ-032 values hold, and there is no BRAM_en pulse until enable and data are present.
REQ-040 Deassert enable at bit_cnt=10 -> output stops after bit 63, lines low; re-enable resumes with the retained holding sample.

Source files
------------

// File: rtl/synth_audio_pkg.sv
// Shared constants, fetch-state type and frame packing for the I2S playback path.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package synth_audio_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SAMPLE_W   = 16;
    localparam int BIT_CNT_W  = 6;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_FULL = 2'd3
    } fetch_state_t;

    // Lay a {left, right} buffer word out as one I2S frame: each half starts
    // with a one-bit delay slot, then the 16-bit sample MSB first, then zero pad.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [2*SAMPLE_W-1:0] word);
        return {1'b0, word[2*SAMPLE_W-1 -: SAMPLE_W], {(SAMPLE_W-1){1'b0}},
                1'b0, word[SAMPLE_W-1:0],             {(SAMPLE_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider: fall/rise strobes every BCLK_HALF clk cycles and the 6-bit bit counter.
// Latency: first rise strobe BCLK_HALF cycles after run goes high; strobes are combinational.
// Backpressure: none; dropping run parks the divider, phase and bit counter at zero.
module i2s_clk_gen
    import synth_audio_pkg::*;
#(
    parameter int BCLK_HALF = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 fall,
    output logic                 rise,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    localparam int             DIV_W    = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             phase;
    logic             div_end;

    assign div_end = run && (div_cnt == DIV_LAST);
    assign fall    = div_end && phase;
    assign rise    = div_end && !phase;

    // Half-period divider; the bit counter advances on every falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (!run) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (div_end) begin
            div_cnt <= '0;
            phase   <= !phase;
            if (phase) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/synth_buffer_i2s_tx.sv
// Plays 32-bit {L,R} words from a ring buffer in BRAM out as 64-bit I2S frames.
// Latency: fetch is 3 clk (req, wait, capture); first BCLK rise BCLK_HALF cycles after enable.
// Backpressure: empty buffer at a frame boundary plays silence and bumps underrun_cnt.
module synth_buffer_i2s_tx
    import synth_audio_pkg::*;
#(
    parameter int          BCLK_HALF = 16,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [31:0]       BRAM_addr,
    output logic              BRAM_en,
    output logic [3:0]        BRAM_we,
    input  logic [31:0]       BRAM_dout,
    output logic [15:0]       underrun_cnt,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_sdata
);

    fetch_state_t            state;
    logic [ADDR_W-1:0]       wr_q;
    logic [31:0]             hold_dat;
    logic                    hold_vld;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [FRAME_BITS-1:0]   frame_word;
    logic                    active;
    logic                    first_pend;
    logic                    fall;
    logic                    rise;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [BIT_CNT_W-1:0]    next_bit;
    logic                    start;
    logic                    at_wrap;
    logic                    wrap_load;
    logic                    first_load;
    logic                    load;
    logic                    stop;

    // The holding register is occupied exactly while the fetch FSM sits in F_FULL.
    assign hold_vld   = (state == F_FULL);
    assign start      = !active && enable;
    assign at_wrap    = fall && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    assign wrap_load  = at_wrap && enable;
    assign stop       = at_wrap && !enable;
    // After a (re)start the frame begins at bit 0, which is always a zero slot,
    // so the load is deferred to the first falling edge; that gives the fetch
    // 2*BCLK_HALF cycles to fill the holding register before anything is lost.
    assign first_load = fall && first_pend;
    assign load       = wrap_load || first_load;
    assign next_bit   = bit_cnt + BIT_CNT_W'(1);
    assign frame_word = hold_vld ? pack_frame(hold_dat) : '0;

    assign BRAM_en   = (state == F_REQ);
    assign BRAM_we   = 4'b0000;
    assign BRAM_addr = BASE_ADDR + (32'(rd_ptr) << 2);

    i2s_clk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .run     (active),
        .fall    (fall),
        .rise    (rise),
        .bit_cnt (bit_cnt)
    );

    // Run control: start immediately on enable, stop only at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            active     <= 1'b0;
            first_pend <= 1'b0;
        end else begin
            if (start) begin
                active <= 1'b1;
            end else if (stop) begin
                active <= 1'b0;
            end
            if (start) begin
                first_pend <= 1'b1;
            end else if (first_load) begin
                first_pend <= 1'b0;
            end
        end
    end

    // Fetch FSM: one word at a time into the holding register; empty compare
    // uses last cycle's wr_ptr so a producer update is never half-seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= F_IDLE;
            wr_q     <= '0;
            rd_ptr   <= '0;
            hold_dat <= '0;
        end else begin
            wr_q <= wr_ptr;
            case (state)
                F_IDLE: begin
                    if (enable && (rd_ptr != wr_q)) begin
                        state <= F_REQ;
                    end
                end
                F_REQ: begin
                    state <= F_WAIT;
                end
                F_WAIT: begin
                    hold_dat <= BRAM_dout;
                    rd_ptr   <= rd_ptr + ADDR_W'(1);
                    state    <= F_FULL;
                end
                F_FULL: begin
                    if (load) begin
                        state <= F_IDLE;
                    end
                end
                default: begin
                    state <= F_IDLE;
                end
            endcase
        end
    end

    // Serializer: all three I2S lines are registered and move only on strobes;
    // lrclk and sdata change only on the falling-edge cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            shift_reg <= '0;
        end else if (rise) begin
            i2s_bclk <= 1'b1;
        end else if (fall) begin
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= next_bit[BIT_CNT_W-1];
            if (stop) begin
                i2s_sdata <= 1'b0;
            end else if (first_load) begin
                i2s_sdata <= frame_word[FRAME_BITS-2];
                shift_reg <= frame_word << 2;
            end else if (wrap_load) begin
                i2s_sdata <= frame_word[FRAME_BITS-1];
                shift_reg <= frame_word << 1;
            end else begin
                i2s_sdata <= shift_reg[FRAME_BITS-1];
                shift_reg <= shift_reg << 1;
            end
        end
    end

    // Count every frame that had to be played as silence, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (load && !hold_vld && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

endmodule
